// File: rtl/fetch_if.sv
// fetch_if: instruction memory and decode-side signals of the fetch stage
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ack;
  logic        branch;
  logic        jump;
  logic        jr;
  logic [31:0] jr_addr;
  modport master (
    output imem_req, imem_addr, instr, pc, pc_plus4, instr_valid,
    input  imem_ready, imem_rdata, instr_ack, branch, jump, jr, jr_addr
  );
  modport slave (
    input  imem_req, imem_addr, instr, pc, pc_plus4, instr_valid,
    output imem_ready, imem_rdata, instr_ack, branch, jump, jr, jr_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches words over req/ready and holds each until acknowledged
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic    clk,
  input logic    rst_n,
  fetch_if.master bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  logic [1:0]  state;
  logic [31:0] fetch_pc;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] next_pc;
  logic [31:0] br_off;
  assign bus.imem_req    = state == FETCH;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = state == HOLD;
  assign bus.instr       = instr_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  // jr outranks jump, which outranks a taken branch
  assign next_pc = bus.jr     ? {bus.jr_addr[31:2], 2'b00} :
                   bus.jump   ? {bus.pc_plus4[31:28], instr_q[25:0], 2'b00} :
                   bus.branch ? bus.pc_plus4 + br_off :
                                bus.pc_plus4;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: if (bus.imem_ready) begin
          instr_q <= bus.imem_rdata;
          pc_q    <= fetch_pc;
          state   <= HOLD;
        end
        HOLD: if (bus.instr_ack) begin
          fetch_pc <= next_pc;
          state    <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch timing, next-PC selection, wait states and reset
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  fetch_if bus ();
  fetch_unit #(.RESET_PC(32'h0000_3000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'h0000_3010 ? 32'h1000_FFFD :
           a == 32'h3000_0000 ? 32'h0C00_0100 : a ^ 32'hDEAD_0000;
  endfunction
  assign bus.imem_rdata = mem(bus.imem_addr);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic br, input logic jp, input logic j_r, input logic [31:0] ja,
                    input logic [31:0] exp, input string tag);
    bus.instr_ack = 1'b1; bus.branch = br; bus.jump = jp; bus.jr = j_r; bus.jr_addr = ja;
    cycle();
    bus.instr_ack = 1'b0; bus.branch = 1'b0; bus.jump = 1'b0; bus.jr = 1'b0;
    chk({tag, "_req"}, {31'd0, bus.imem_req}, 32'd1);
    chk({tag, "_addr"}, bus.imem_addr, exp);
    chk({tag, "_vld0"}, {31'd0, bus.instr_valid}, 32'd0);
    cycle();
    chk({tag, "_vld1"}, {31'd0, bus.instr_valid}, 32'd1);
    chk({tag, "_pc"}, bus.pc, exp);
    chk({tag, "_instr"}, bus.instr, mem(exp));
  endtask
  initial begin
    bus.imem_ready = 1'b1; bus.instr_ack = 1'b0;
    bus.branch = 1'b0; bus.jump = 1'b0; bus.jr = 1'b0; bus.jr_addr = '0;
    repeat (2) cycle();
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0000_3000);
    chk("rst_vld", {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_pc", bus.pc, 32'h0000_3000);
    @(negedge clk) rst_n = 1'b1;
    cycle();
    chk("first_req", {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0000_3000);
    chk("first_vld0", {31'd0, bus.instr_valid}, 32'd0);
    cycle();
    chk("first_vld1", {31'd0, bus.instr_valid}, 32'd1);
    chk("first_instr", bus.instr, mem(32'h0000_3000));
    chk("first_pc4", bus.pc_plus4, 32'h0000_3004);
    for (int i = 1; i <= 4; i++) go(0, 0, 0, 0, 32'h0000_3000 + 32'(4 * i), "seq");
    chk("br_instr", bus.instr, 32'h1000_FFFD);
    go(1, 0, 0, 0, 32'h0000_3008, "branch");
    go(0, 0, 0, 0, 32'h0000_300C, "seq2");
    go(0, 0, 0, 0, 32'h0000_3010, "seq3");
    go(1, 0, 1, 32'h0000_4002, 32'h0000_4000, "jr_over_br");
    go(0, 0, 1, 32'h3000_0000, 32'h3000_0000, "jr");
    chk("jal_pc4", bus.pc_plus4, 32'h3000_0004);
    go(1, 1, 0, 0, 32'h3000_0400, "jal");
    go(0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, "jr_mis");
    chk("wrap_pc4", bus.pc_plus4, 32'h0);
    go(0, 0, 0, 0, 32'h0, "wrap");
    bus.imem_ready = 1'b0;
    bus.instr_ack = 1'b1;
    cycle();
    bus.instr_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ws_addr", bus.imem_addr, 32'h4);
      chk("ws_vld", {31'd0, bus.instr_valid}, 32'd0);
      cycle();
    end
    bus.imem_ready = 1'b1;
    chk("ws_addr4", bus.imem_addr, 32'h4);
    cycle();
    chk("ws_vld1", {31'd0, bus.instr_valid}, 32'd1);
    chk("ws_instr", bus.instr, mem(32'h4));
    bus.jr = 1'b1; bus.jr_addr = 32'h0000_8000; bus.branch = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("hold_instr", bus.instr, mem(32'h4));
      chk("hold_pc", bus.pc, 32'h4);
      chk("hold_vld", {31'd0, bus.instr_valid}, 32'd1);
    end
    bus.jr = 1'b0; bus.branch = 1'b0;
    go(0, 0, 0, 0, 32'h8, "after_hold");
    bus.imem_ready = 1'b0;
    bus.instr_ack = 1'b1;
    cycle();
    bus.instr_ack = 1'b0;
    chk("rf_req1", {31'd0, bus.imem_req}, 32'd1);
    chk("rf_addr", bus.imem_addr, 32'hC);
    #2 rst_n = 1'b0;
    #1;
    chk("rf_req0", {31'd0, bus.imem_req}, 32'd0);
    chk("rf_addr_rst", bus.imem_addr, 32'h0000_3000);
    bus.imem_ready = 1'b1;
    cycle();
    chk("rf_vld", {31'd0, bus.instr_valid}, 32'd0);
    chk("rf_instr", bus.instr, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    cycle();
    chk("rs_addr", bus.imem_addr, 32'h0000_3000);
    cycle();
    chk("rs_vld", {31'd0, bus.instr_valid}, 32'd1);
    chk("rs_instr", bus.instr, mem(32'h0000_3000));
    chk("rs_pc", bus.pc, 32'h0000_3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
